nand_seq_ctrl: RTL and testbench
================================

Name: nand_seq_ctrl

Overview:
- Sequencing controller that computes a selectable bitwise logic function of two operands using a single shared WIDTH-bit NAND unit.
- The NAND unit is built from per-bit Nand_G instances.
- Complex functions (AND/OR/XOR/…) are built from multiple NAND passes, one pass per clock, with intermediates held in internal temp registers.
- Sits between a requester (valid/ready in) and a consumer (valid/ready out). It is the reusable "NAND-only ALU" for the basic-gate design set.

Parameters:
- WIDTH, 8: operand and result width in bits.
- CNT_W, 16: width of the saturating NAND-pass statistics counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- op  input  3  function select; sampled on accept.
- A  input  WIDTH  operand A; sampled on accept.
- B  input  WIDTH  operand B; sampled on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Out  output  WIDTH  result.
- out_err  output  1  request used a reserved op.
- pass_count  output  CNT_W  total NAND passes executed since reset; saturates at all-ones.

Behaviour:
- Reset (rst_n low, takes effect immediately, any state): state=IDLE, step=0, temps=0.
  - Output values under reset: out_valid=0, Out=0, out_err=0, pass_count=0, in_ready=1.
  - A request or result in flight is discarded with no partial output.
- in_ready is combinational: 1 exactly when state==IDLE.
- States are IDLE, EXEC and DONE.
- IDLE:
  - Accept on a rising edge with in_valid & in_ready.
  - Capture op/A/B into registers, step=0.
  - If op==7, go to DONE with out_err=1 and Out=0 (0 passes). Otherwise go to EXEC.
- EXEC:
  - Each edge evaluates exactly one NAND nand(X,Y) = ~(X&Y) on the shared unit, writes the result to a temp or to Out, increments step, and increments pass_count (saturating).
  - After the final pass of the op, go to DONE with out_valid=1.
- Pass sequences (T, U, V are temps; N = pass count):
  - op0 NOT, N=1: Out=nand(A,A).
  - op1 NAND, N=1: Out=nand(A,B).
  - op2 AND, N=2: T=nand(A,B); Out=nand(T,T).
  - op3 OR, N=3: T=nand(A,A); U=nand(B,B); Out=nand(T,U).
  - op4 NOR, N=4: OR sequence into V; Out=nand(V,V).
  - op5 XOR, N=4: T=nand(A,B); U=nand(A,T); V=nand(B,T); Out=nand(U,V).
  - op6 XNOR, N=5: XOR sequence into a temp; Out=nand(temp,temp).
- Latency:
  - For op0–6, out_valid is high in the cycle after edge k+N, where k is the accept edge.
  - For op7, out_valid is high after edge k+1.
- DONE:
  - out_valid=1; Out and out_err are held stable while out_ready=0.
  - On an edge with out_valid & out_ready: go to IDLE, out_valid=0, out_err=0, Out holds its last value.
  - A new request cannot be accepted in the same edge the result leaves DONE. in_ready rises the following cycle, so minimum request spacing is N+2 cycles.
- A, B and op changing during EXEC/DONE have no effect.
- in_valid during EXEC/DONE is ignored and not accepted.
- The Out register is written only on the final pass; it never shows an intermediate value.
- pass_count does not wrap: at 2^CNT_W−1 it holds.
- op7 does not increment pass_count.

Test Plan:
- Reset, then WIDTH=8, A=0xF0, B=0xCC, ops 0..6 issued one at a time with out_ready=1.
  - Required Out values: 0x0F, 0x3F, 0xC0, 0xFC, 0x03, 0x3C, 0xC3.
  - out_valid must appear 1,1,2,3,4,4,5 cycles after accept.
  - pass_count must end at 20.
- op=7, A=0xFF, B=0xFF: out_valid after 1 cycle with out_err=1, Out=0x00, pass_count unchanged. The next request then clears out_err.
- XOR with out_ready=0 for 10 cycles after out_valid, while A/B/op/in_valid toggle randomly.
  - Out stays 0x3C, in_ready stays 0, no second accept.
  - Raising out_ready completes the transfer, and in_ready=1 on the next cycle.
- Assert rst_n=0 mid-EXEC of XNOR, at step 2.
  - Immediately: out_valid=0, Out=0, pass_count=0, in_ready=1.
  - After release, a NOT of A=0x55 yields 0xAA.
- Back-to-back AND requests with in_valid held high and out_ready=1: accepts are spaced exactly 4 cycles apart, and results are correct.
- Force pass_count near saturation, e.g. CNT_W=4 with 15 NOT ops followed by 1 OR: the counter holds at 0xF.

Source files
------------

// File: rtl/nand_seq_ctrl.sv
// NAND-only sequencing ALU: evaluates NOT/NAND/AND/OR/NOR/XOR/XNOR as a chain of
// passes through one shared WIDTH-bit NAND unit, one pass per clock.

module Nand_G (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = ~(a_i & b_i);
endmodule

module nand_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             out_err,
  output logic [CNT_W-1:0] pass_count
);

  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2;

  localparam logic [2:0] SRC_A = 3'd0, SRC_B = 3'd1, SRC_T = 3'd2, SRC_U = 3'd3, SRC_V = 3'd4;
  localparam logic [1:0] DST_T = 2'd0, DST_U = 2'd1, DST_V = 2'd2, DST_OUT = 2'd3;

  typedef struct packed {
    logic [2:0] src_x;
    logic [2:0] src_y;
    logic [1:0] dst;
    logic       last;
    logic       nand_en;
  } pass_t;

  logic [1:0]       state_q, state_d;
  logic [2:0]       step_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, t_q, u_q, v_q, out_q;
  logic             err_q;
  logic [CNT_W-1:0] pass_q;

  pass_t            pass;
  logic [WIDTH-1:0] nand_x, nand_y, nand_r;

  function automatic pass_t mk(input logic [2:0] x, input logic [2:0] y,
                               input logic [1:0] d, input logic l);
    mk = '{src_x: x, src_y: y, dst: d, last: l, nand_en: 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [2:0] s);
    case (s)
      SRC_A:   pick = a_q;
      SRC_B:   pick = b_q;
      SRC_T:   pick = t_q;
      SRC_U:   pick = u_q;
      default: pick = v_q;
    endcase
  endfunction

  // Pass schedule: which operands feed the NAND unit and where its result goes.
  always_comb begin
    pass = '{src_x: SRC_A, src_y: SRC_A, dst: DST_OUT, last: 1'b1, nand_en: 1'b0};
    case (op_q)
      3'd0: pass = mk(SRC_A, SRC_A, DST_OUT, 1'b1);
      3'd1: pass = mk(SRC_A, SRC_B, DST_OUT, 1'b1);
      3'd2: pass = (step_q == 3'd0) ? mk(SRC_A, SRC_B, DST_T, 1'b0)
                                    : mk(SRC_T, SRC_T, DST_OUT, 1'b1);
      3'd3, 3'd4:
        case (step_q)
          3'd0:    pass = mk(SRC_A, SRC_A, DST_T, 1'b0);
          3'd1:    pass = mk(SRC_B, SRC_B, DST_U, 1'b0);
          3'd2:    pass = (op_q == 3'd3) ? mk(SRC_T, SRC_U, DST_OUT, 1'b1)
                                         : mk(SRC_T, SRC_U, DST_V, 1'b0);
          default: pass = mk(SRC_V, SRC_V, DST_OUT, 1'b1);
        endcase
      3'd5, 3'd6:
        case (step_q)
          3'd0:    pass = mk(SRC_A, SRC_B, DST_T, 1'b0);
          3'd1:    pass = mk(SRC_A, SRC_T, DST_U, 1'b0);
          3'd2:    pass = mk(SRC_B, SRC_T, DST_V, 1'b0);
          3'd3:    pass = (op_q == 3'd5) ? mk(SRC_U, SRC_V, DST_OUT, 1'b1)
                                         : mk(SRC_U, SRC_V, DST_T, 1'b0);
          default: pass = mk(SRC_T, SRC_T, DST_OUT, 1'b1);
        endcase
      default: ; // reserved op: one idle cycle, no pass
    endcase
  end

  assign nand_x = pick(pass.src_x);
  assign nand_y = pick(pass.src_y);

  for (genvar i = 0; i < WIDTH; i++) begin : g_nand
    Nand_G u_nand (.a_i(nand_x[i]), .b_i(nand_y[i]), .y_o(nand_r[i]));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EXEC;
      S_EXEC:  if (pass.last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register, including the operand and temp registers, is cleared by
  // the async reset so an aborted request leaves nothing behind; all updates use <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      u_q     <= '0;
      v_q     <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q   <= op;
          a_q    <= A;
          b_q    <= B;
          step_q <= '0;
        end
        S_EXEC: begin
          step_q <= step_q + 3'd1;
          if (pass.nand_en) begin
            case (pass.dst)
              DST_T:   t_q   <= nand_r;
              DST_U:   u_q   <= nand_r;
              DST_V:   v_q   <= nand_r;
              default: out_q <= nand_r;
            endcase
            if (pass_q != {CNT_W{1'b1}}) pass_q <= pass_q + 1'b1;
          end else begin
            out_q <= '0;
            err_q <= 1'b1;
          end
        end
        S_DONE: if (out_ready) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign Out        = out_q;
  assign out_err    = err_q;
  assign pass_count = pass_q;

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// Directed bench for nand_seq_ctrl: op table, reserved op, back-pressure,
// mid-sequence reset, back-to-back spacing and counter saturation.

module tb_nand_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  op;
  logic [7:0]  A, B, Out;
  logic [15:0] pass_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
  logic [2:0]  s_op;
  logic [7:0]  s_A, s_B, s_Out;
  logic [3:0]  s_pass_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  nand_seq_ctrl #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
    .out_err(out_err), .pass_count(pass_count)
  );

  nand_seq_ctrl #(.WIDTH(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .A(s_A), .B(s_B), .out_valid(s_out_valid), .out_ready(s_out_ready), .Out(s_Out),
    .out_err(s_out_err), .pass_count(s_pass_count)
  );

  // Waits for in_ready, presents one request, returns cycles from accept to out_valid.
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       output int lat);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    op = o; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic sat_issue(input logic [2:0] o, output logic [7:0] res);
    int guard = 0;
    @(negedge clk);
    while (!s_in_ready && guard < 50) begin @(negedge clk); guard++; end
    s_op = o; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    guard = 0;
    while (!s_out_valid && guard < 20) begin @(negedge clk); guard++; end
    res = s_Out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; op = '0; A = '0; B = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_op = '0; s_A = 8'hF0; s_B = 8'hCC; s_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({in_ready, out_valid, out_err, Out, pass_count} !== {1'b1, 1'b0, 1'b0, 8'h00, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b vld=%b err=%b Out=%h cnt=%0d, want rdy=1 vld=0 err=0 Out=00 cnt=0",
               in_ready, out_valid, out_err, Out, pass_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ops();
    logic [7:0] exp_out [7] = '{8'h0F, 8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3};
    int         exp_lat [7] = '{1, 1, 2, 3, 4, 4, 5};
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue(3'(i), 8'hF0, 8'hCC, lat);
      tests_run++;
      if (lat !== exp_lat[i]) begin
        tests_failed++;
        $display("FAIL op%0d_latency: got %0d cycles, want %0d", i, lat, exp_lat[i]);
      end
      tests_run++;
      if (Out !== exp_out[i]) begin
        tests_failed++;
        $display("FAIL op%0d_result: got %h, want %h", i, Out, exp_out[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (pass_count !== 16'd20) begin
      tests_failed++;
      $display("FAIL op_table_pass_count: got %0d, want 20", pass_count);
    end
  endtask

  task automatic test_reserved_op();
    int lat;
    issue(3'd7, 8'hFF, 8'hFF, lat);
    tests_run++;
    if ({lat == 1, out_err, Out} !== {1'b1, 1'b1, 8'h00}) begin
      tests_failed++;
      $display("FAIL op7_result: lat=%0d err=%b Out=%h, want lat=1 err=1 Out=00", lat, out_err, Out);
    end
    tests_run++;
    if (pass_count !== 16'd20) begin
      tests_failed++;
      $display("FAIL op7_pass_count: got %0d, want 20", pass_count);
    end
    issue(3'd0, 8'hF0, 8'hCC, lat);
    tests_run++;
    if ({out_err, Out} !== {1'b0, 8'h0F}) begin
      tests_failed++;
      $display("FAIL op7_err_clear: err=%b Out=%h, want err=0 Out=0f", out_err, Out);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] base;
    @(negedge clk);
    base = pass_count;
    out_ready = 1'b0;
    issue(3'd5, 8'hF0, 8'hCC, lat);
    for (int i = 0; i < 10; i++) begin
      {A, B, op, in_valid} = 20'($urandom);
      @(negedge clk);
      tests_run++;
      if ({out_valid, in_ready, Out} !== {1'b1, 1'b0, 8'h3C}) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: vld=%b rdy=%b Out=%h, want vld=1 rdy=0 Out=3c",
                 i, out_valid, in_ready, Out);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, Out} !== {1'b0, 1'b1, 8'h3C}) begin
      tests_failed++;
      $display("FAIL hold_release: vld=%b rdy=%b Out=%h, want vld=0 rdy=1 Out=3c",
               out_valid, in_ready, Out);
    end
    tests_run++;
    if (pass_count !== base + 16'd4) begin
      tests_failed++;
      $display("FAIL hold_no_second_accept: cnt=%0d, want %0d", pass_count, base + 16'd4);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    @(negedge clk);
    op = 3'd6; A = 8'hF0; B = 8'hCC; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, Out, pass_count} !== {1'b0, 1'b1, 8'h00, 16'h0}) begin
      tests_failed++;
      $display("FAIL mid_reset: vld=%b rdy=%b Out=%h cnt=%0d, want vld=0 rdy=1 Out=00 cnt=0",
               out_valid, in_ready, Out, pass_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 8'h55, 8'h00, lat);
    tests_run++;
    if ({lat == 1, Out} !== {1'b1, 8'hAA}) begin
      tests_failed++;
      $display("FAIL post_reset_not: lat=%0d Out=%h, want lat=1 Out=aa", lat, Out);
    end
    tests_run++;
    if (pass_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL post_reset_count: got %0d, want 1", pass_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'hF0, 8'hAA, 8'hFF};
    logic [7:0] vb [3] = '{8'hCC, 8'h0F, 8'h81};
    logic [7:0] ve [3] = '{8'hC0, 8'h0A, 8'h81};
    int acc [3] = '{0, 0, 0};
    int n = 0;
    int r = 0;
    @(negedge clk);
    op = 3'd2; out_ready = 1'b1; in_valid = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (out_valid && r < 3) begin
        tests_run++;
        if (Out !== ve[r]) begin
          tests_failed++;
          $display("FAIL b2b_result%0d: got %h, want %h", r, Out, ve[r]);
        end
        r++;
      end
      if (n == 3) in_valid = 1'b0;
      else if (in_ready) begin
        A = va[n]; B = vb[n]; acc[n] = cyc; n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++;
    if ({n == 3, r == 3, acc[1] - acc[0] == 4, acc[2] - acc[1] == 4} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL b2b_spacing: accepts=%0d results=%0d at cycles %0d,%0d,%0d, want 3 results 4 apart",
               n, r, acc[0], acc[1], acc[2]);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] res;
    for (int i = 0; i < 15; i++) sat_issue(3'd0, res);
    @(negedge clk);
    tests_run++;
    if ({s_pass_count, res} !== {4'hF, 8'h0F}) begin
      tests_failed++;
      $display("FAIL sat_15_not: cnt=%h Out=%h, want cnt=f Out=0f", s_pass_count, res);
    end
    sat_issue(3'd3, res);
    @(negedge clk);
    tests_run++;
    if ({s_pass_count, res} !== {4'hF, 8'hFC}) begin
      tests_failed++;
      $display("FAIL sat_hold: cnt=%h Out=%h, want cnt=f Out=fc", s_pass_count, res);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_reserved_op();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
